serv_mtimer: RTL and testbench

- Machine-timer peripheral that produces the timer-interrupt line consumed by the CSR stage (its i_mtip input).
- Holds a 64-bit mtime counter and a 64-bit mtimecmp register, both memory-mapped on a 32-bit Wishbone slave port.
- Asserts o_irq while mtime >= mtimecmp.
- Counting freezes while the core is debug-halted, so single-stepping does not flood the core with timer interrupts.

---
 rtl/serv_timer_pkg.sv | 24 ++
 rtl/serv_mtimer_prescaler.sv | 40 ++++
 rtl/serv_mtimer.sv | 114 +++++++++++
 tb/tb_serv_mtimer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_timer_pkg.sv
// Shared constants and helpers for the serv machine timer.
// Word addresses of the four timer registers and the mtimecmp reset value.
package serv_timer_pkg;

    localparam logic [1:0] MTIME_LO    = 2'd0;
    localparam logic [1:0] MTIME_HI    = 2'd1;
    localparam logic [1:0] MTIMECMP_LO = 2'd2;
    localparam logic [1:0] MTIMECMP_HI = 2'd3;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace only the byte lanes enabled in sel.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/serv_mtimer_prescaler.sv
// Divides the core clock down to the mtime increment rate.
// Emits a tick when the count reaches PRESCALE-1, then wraps to 0.
module serv_mtimer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_halt,
    output logic o_tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        o_tick  = !i_halt && (count_q == LAST);
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (o_tick) begin
            count_d = '0;
        end else if (!i_halt) begin
            count_d = count_q + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serv_mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp on a 32-bit Wishbone slave,
// raising o_irq while mtime >= mtimecmp; counting freezes in debug halt.
module serv_mtimer
    import serv_timer_pkg::*;
#(
    parameter int unsigned PRESCALE       = 1,
    parameter              RESET_STRATEGY = "MINI"
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_dbg_halt,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_irq
);

    logic        ack_q, ack_d;
    logic        irq_q, irq_d;
    logic [31:0] rdt_q, rdt_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;

    logic        access;
    logic        wr_en;
    logic        mtime_wr;
    logic        tick;
    logic [31:0] rd_word;

    serv_mtimer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (mtime_wr),
        .i_halt  (i_dbg_halt),
        .o_tick  (tick)
    );

    // The reset term keeps the data registers untouched on a reset edge even when they have no reset.
    always_comb begin
        access   = i_wb_cyc && !ack_q && !i_rst;
        wr_en    = access && i_wb_we;
        mtime_wr = wr_en && !i_wb_adr[1];
        ack_d    = access;
        irq_d    = (mtime_q >= mtimecmp_q);

        unique case (i_wb_adr)
            MTIME_LO:    rd_word = mtime_q[31:0];
            MTIME_HI:    rd_word = mtime_q[63:32];
            MTIMECMP_LO: rd_word = mtimecmp_q[31:0];
            default:     rd_word = mtimecmp_q[63:32];
        endcase
        rdt_d = (access && !i_wb_we) ? rd_word : rdt_q;

        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (mtime_wr) begin
            if (i_wb_adr == MTIME_LO) begin
                mtime_d[31:0] = byte_merge(mtime_q[31:0], i_wb_dat, i_wb_sel);
            end else begin
                mtime_d[63:32] = byte_merge(mtime_q[63:32], i_wb_dat, i_wb_sel);
            end
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wr_en && (i_wb_adr == MTIMECMP_LO)) begin
            mtimecmp_d[31:0] = byte_merge(mtimecmp_q[31:0], i_wb_dat, i_wb_sel);
        end else if (wr_en && (i_wb_adr == MTIMECMP_HI)) begin
            mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], i_wb_dat, i_wb_sel);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack_q <= 1'b0;
            irq_q <= 1'b0;
            rdt_q <= '0;
        end else begin
            ack_q <= ack_d;
            irq_q <= irq_d;
            rdt_q <= rdt_d;
        end
    end

    generate
        if (RESET_STRATEGY == "ALL") begin : g_rst_all
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    mtime_q    <= '0;
                    mtimecmp_q <= MTIMECMP_RST;
                end else begin
                    mtime_q    <= mtime_d;
                    mtimecmp_q <= mtimecmp_d;
                end
            end
        end else begin : g_rst_mini
            // NOTE: the wide data registers are deliberately left without reset; software writes them before use.
            always_ff @(posedge i_clk) begin
                mtime_q    <= mtime_d;
                mtimecmp_q <= mtimecmp_d;
            end
        end
    endgenerate

    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;
    assign o_irq    = irq_q;

endmodule

// File: tb/tb_serv_mtimer.sv
// Self-checking bench for serv_mtimer: a PRESCALE=1/"ALL" instance and a
// PRESCALE=4/"MINI" instance, with a read-data scoreboard fed by a timing model.
module tb_serv_mtimer;

    localparam logic [1:0] A_MT_LO  = 2'd0;
    localparam logic [1:0] A_MT_HI  = 2'd1;
    localparam logic [1:0] A_CMP_LO = 2'd2;
    localparam logic [1:0] A_CMP_HI = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dbg_halt = 1'b1;
    logic [1:0]  wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        cyc1 = 1'b0;
    logic        cyc4 = 1'b0;
    logic [31:0] rdt1, rdt4;
    logic        ack1, ack4, irq1, irq4;

    int          n_cmp = 0;
    int          n_fail = 0;
    longint      cyc_cnt = 0;
    logic [31:0] exp_q[$];

    // Timing model: mtime value after edge k = base + (k - edge) / prescale.
    logic [63:0] mt_base[2];
    longint      mt_edge[2];
    logic [63:0] cmp_m[2];
    bit          halted = 1'b1;
    logic        irq_at_ack;

    serv_mtimer #(.PRESCALE(1), .RESET_STRATEGY("ALL")) dut1 (
        .i_clk(clk), .i_rst(rst), .i_dbg_halt(dbg_halt),
        .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel),
        .i_wb_we(wb_we), .i_wb_cyc(cyc1),
        .o_wb_rdt(rdt1), .o_wb_ack(ack1), .o_irq(irq1)
    );

    serv_mtimer #(.PRESCALE(4), .RESET_STRATEGY("MINI")) dut4 (
        .i_clk(clk), .i_rst(rst), .i_dbg_halt(dbg_halt),
        .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel),
        .i_wb_we(wb_we), .i_wb_cyc(cyc4),
        .o_wb_rdt(rdt4), .o_wb_ack(ack4), .o_irq(irq4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    function automatic logic [63:0] mt_at(input int inst, input longint k);
        longint steps;
        if (halted) return mt_base[inst];
        steps = (k - mt_edge[inst]) / ((inst == 0) ? 1 : 4);
        return mt_base[inst] + 64'(steps);
    endfunction

    task automatic set_halt(input bit v);
        @(negedge clk);
        if (v) begin
            for (int i = 0; i < 2; i++) mt_base[i] = mt_at(i, cyc_cnt);
            halted = 1'b1;
        end else begin
            halted = 1'b0;
            for (int i = 0; i < 2; i++) mt_edge[i] = cyc_cnt;
        end
        dbg_halt = v;
    endtask

    // One Wishbone transaction; read expectations go through the scoreboard queue.
    task automatic bus(input int inst, input logic [1:0] adr, input bit we,
                       input logic [31:0] dat, input logic [3:0] sel,
                       output logic [31:0] rd);
        logic [63:0] pre;
        logic [31:0] exp_word;
        longint      k;
        bit          got;
        @(negedge clk);
        wb_adr = adr; wb_we = we; wb_dat = dat; wb_sel = sel;
        if (inst == 0) cyc1 = 1'b1; else cyc4 = 1'b1;
        k = cyc_cnt + 1;
        if (!we) begin
            pre = mt_at(inst, k - 1);
            case (adr)
                A_MT_LO:  exp_q.push_back(pre[31:0]);
                A_MT_HI:  exp_q.push_back(pre[63:32]);
                A_CMP_LO: exp_q.push_back(cmp_m[inst][31:0]);
                default:  exp_q.push_back(cmp_m[inst][63:32]);
            endcase
        end
        got = 1'b0;
        for (int t = 0; t < 4 && !got; t++) begin
            @(negedge clk);
            got = (inst == 0) ? ack1 : ack4;
        end
        cyc1 = 1'b0; cyc4 = 1'b0;
        rd = (inst == 0) ? rdt1 : rdt4;
        irq_at_ack = (inst == 0) ? irq1 : irq4;
        n_cmp++;
        if (!got || cyc_cnt != k) begin
            n_fail++;
            $display("FAIL ack_latency inst%0d adr%0d: ack at edge %0d (got=%0d), required edge %0d",
                     inst, adr, cyc_cnt, got, k);
        end
        if (!we) begin
            exp_word = exp_q.pop_front();
            n_cmp++;
            if (rd !== exp_word) begin
                n_fail++;
                $display("FAIL read_data inst%0d adr%0d: got %08h, required %08h", inst, adr, rd, exp_word);
            end
        end else if (got) begin
            case (adr)
                A_MT_LO, A_MT_HI: begin
                    pre = mt_at(inst, k - 1);
                    if (adr == A_MT_LO) pre[31:0] = merge(pre[31:0], dat, sel);
                    else                pre[63:32] = merge(pre[63:32], dat, sel);
                    mt_base[inst] = pre;
                    mt_edge[inst] = k;
                end
                A_CMP_LO: cmp_m[inst][31:0]  = merge(cmp_m[inst][31:0], dat, sel);
                default:  cmp_m[inst][63:32] = merge(cmp_m[inst][63:32], dat, sel);
            endcase
        end
        @(negedge clk);
        n_cmp++;
        if (((inst == 0) ? ack1 : ack4) !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_width inst%0d adr%0d: ack still %b one cycle later, required 0",
                     inst, adr, (inst == 0) ? ack1 : ack4);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mt_base[0] = '0;
        mt_edge[0] = cyc_cnt;
        cmp_m[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        cmp_m[1] = 'x;
        n_cmp++;
        if ({ack1, irq1, rdt1, ack4, irq4, rdt4} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack/irq/rdt = %b %b %08h / %b %b %08h, required all zero",
                     ack1, irq1, rdt1, ack4, irq4, rdt4);
        end
        for (int a = 0; a < 4; a++) bus(0, 2'(a), 1'b0, '0, 4'hF, rd);
        set_halt(1'b0);
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        longint      w;
        bus(0, A_MT_HI, 1'b1, 32'h0, 4'hF, rd);
        bus(0, A_MT_LO, 1'b1, 32'h0, 4'hF, rd);
        w = mt_edge[0];
        bus(0, A_CMP_HI, 1'b1, 32'h0, 4'hF, rd);
        bus(0, A_CMP_LO, 1'b1, 32'd20, 4'hF, rd);
        for (int t = 0; t < 100 && cyc_cnt < w + 20; t++) @(negedge clk);
        n_cmp++;
        if (irq1 !== 1'b0 || cyc_cnt != w + 20) begin
            n_fail++;
            $display("FAIL irq_before_match: irq=%b at edge %0d, required 0 at edge %0d", irq1, cyc_cnt, w + 20);
        end
        @(negedge clk);
        n_cmp++;
        if (irq1 !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_rise: irq=%b one cycle after mtime reached 20, required 1", irq1);
        end
        bus(0, A_CMP_LO, 1'b1, 32'd100, 4'hF, rd);
        n_cmp++;
        if (irq_at_ack !== 1'b1 || irq1 !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clear: irq at ack=%b, one cycle later=%b, required 1 then 0", irq_at_ack, irq1);
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd;
        bus(0, A_CMP_LO, 1'b1, 32'h1122_3344, 4'hF, rd);
        bus(0, A_CMP_LO, 1'b1, 32'h0000_AB00, 4'b0010, rd);
        bus(0, A_CMP_LO, 1'b0, '0, 4'h0, rd);
        n_cmp++;
        if (rd !== 32'h1122_AB44) begin
            n_fail++;
            $display("FAIL byte_write: mtimecmp_lo=%08h, required 1122ab44", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        @(negedge clk);
        wb_adr = A_CMP_HI; wb_we = 1'b0; cyc1 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            pat[3-t] = ack1;
        end
        cyc1 = 1'b0;
        n_cmp++;
        if (pat !== 4'b1010 || rdt1 !== cmp_m[0][63:32]) begin
            n_fail++;
            $display("FAIL back_to_back: ack pattern %b rdt %08h, required 1010 and %08h",
                     pat, rdt1, cmp_m[0][63:32]);
        end
        @(negedge clk);
    endtask

    task automatic test_dbg_halt();
        logic [31:0] rd;
        logic        irq0;
        bit          irq_moved;
        set_halt(1'b1);
        bus(0, A_MT_LO, 1'b1, 32'd5, 4'hF, rd);
        irq0 = irq1;
        irq_moved = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (irq1 !== irq0) irq_moved = 1'b1;
        end
        n_cmp++;
        if (irq_moved) begin
            n_fail++;
            $display("FAIL halt_irq: irq changed during debug halt, started at %b", irq0);
        end
        bus(0, A_MT_LO, 1'b0, '0, 4'h0, rd);
        bus(0, A_MT_LO, 1'b0, '0, 4'h0, rd);
        set_halt(1'b0);
        bus(0, A_MT_LO, 1'b0, '0, 4'h0, rd);
        bus(0, A_MT_LO, 1'b0, '0, 4'h0, rd);
    endtask

    task automatic test_prescale();
        logic [31:0] rd;
        bus(1, A_MT_LO, 1'b1, 32'h0, 4'hF, rd);
        repeat (40) @(negedge clk);
        bus(1, A_MT_LO, 1'b0, '0, 4'h0, rd);
        n_cmp++;
        if (rd < 32'd9 || rd > 32'd11) begin
            n_fail++;
            $display("FAIL prescale_range: mtime_lo=%0d after ~42 cycles, required 9..11", rd);
        end
        for (int i = 0; i < 4; i++) bus(1, A_MT_LO, 1'b0, '0, 4'h0, rd);
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        bus(0, A_MT_HI, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        bus(0, A_MT_LO, 1'b1, 32'hFFFF_FFFE, 4'hF, rd);
        bus(0, A_MT_HI, 1'b0, '0, 4'h0, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_hi: mtime_hi=%08h after wrap, required 00000000", rd);
        end
        bus(0, A_MT_LO, 1'b0, '0, 4'h0, rd);
    endtask

    task automatic test_reset_mid_txn();
        logic [31:0] rd;
        bus(1, A_CMP_LO, 1'b1, 32'h0000_0055, 4'hF, rd);
        @(negedge clk);
        wb_adr = A_CMP_LO; wb_we = 1'b1; wb_dat = 32'h0000_00AA; wb_sel = 4'hF;
        cyc4 = 1'b1; rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ack4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drops_ack: ack=%b on reset edge, required 0", ack4);
        end
        rst = 1'b0; cyc4 = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        bus(1, A_CMP_LO, 1'b0, '0, 4'h0, rd);
        n_cmp++;
        if (rd !== 32'h0000_0055) begin
            n_fail++;
            $display("FAIL reset_no_write: mtimecmp_lo=%08h, required 00000055", rd);
        end
    endtask

    initial begin
        test_reset();
        test_irq();
        test_byte_write();
        test_back_to_back();
        test_dbg_halt();
        test_prescale();
        test_wrap();
        test_reset_mid_txn();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
